cva6_stlb_responder: RTL and testbench

- Shared second-level TLB: the responder end of the L1 ITLB/DTLB miss interface.
- Accepts miss requests from the 2-entry instruction and data L1 TLBs and looks them up in a 64-entry direct-mapped Sv39 array.
- Answers hits directly. On a miss it initiates a page-table walk, then fills the array and responds.
- Sits between the MMU's L1 TLBs and the PTW in the cv64a6 MMU configuration (UseSharedTlb=1).

---
 rtl/cva6_stlb_pkg.sv | 43 ++++
 rtl/cva6_stlb_responder_if.sv | 51 +++++
 rtl/cva6_stlb_rr_arb2.sv | 37 +++
 rtl/cva6_stlb_responder.sv | 174 +++++++++++++++++
 tb/tb_cva6_stlb_responder.sv | 449 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cva6_stlb_pkg.sv
// Shared-TLB responder package: Sv39 widths, PTE bit positions, leaf level
// encodings, FSM state encodings and the array entry layout.
package cva6_stlb_pkg;

   localparam int unsigned SV39_VPN_W  = 27;
   localparam int unsigned SV39_PPN_W  = 44;
   localparam int unsigned SV39_ASID_W = 16;

   // PTE bit positions inside perm = {D,A,G,U,X,W,R,V}
   localparam int unsigned PERM_V = 0;
   localparam int unsigned PERM_R = 1;
   localparam int unsigned PERM_W = 2;
   localparam int unsigned PERM_X = 3;
   localparam int unsigned PERM_U = 4;
   localparam int unsigned PERM_G = 5;
   localparam int unsigned PERM_A = 6;
   localparam int unsigned PERM_D = 7;

   localparam logic [1:0] LVL_4K = 2'd0;
   localparam logic [1:0] LVL_2M = 2'd1;
   localparam logic [1:0] LVL_1G = 2'd2;

   // requester bit positions in the arbiter request/grant vectors
   localparam int unsigned REQ_ITLB = 0;
   localparam int unsigned REQ_DTLB = 1;

   typedef logic [2:0] stlb_state_t;
   localparam stlb_state_t ST_IDLE      = 3'd0;
   localparam stlb_state_t ST_LOOKUP    = 3'd1;
   localparam stlb_state_t ST_WALK_REQ  = 3'd2;
   localparam stlb_state_t ST_WALK_WAIT = 3'd3;
   localparam stlb_state_t ST_RESP      = 3'd4;

   // tag is held right-aligned in a full-VPN-wide field
   typedef struct packed {
      logic                   valid;
      logic [SV39_VPN_W-1:0]  tag;
      logic [SV39_ASID_W-1:0] asid;
      logic [SV39_PPN_W-1:0]  ppn;
      logic [7:0]             perm;
   } stlb_entry_t;

endpackage

// File: rtl/cva6_stlb_responder_if.sv
// L1 TLB miss / response bus and PTW walk bus of the shared TLB.
// Signal suffixes are relative to the responder (slave modport).
interface cva6_stlb_responder_if
   import cva6_stlb_pkg::*;
#(
   parameter int unsigned VPN_W = SV39_VPN_W,
   parameter int unsigned PPN_W = SV39_PPN_W
) ();

   logic             itlb_req_valid_i;
   logic             itlb_req_ready_o;
   logic [VPN_W-1:0] itlb_req_vpn_i;
   logic             dtlb_req_valid_i;
   logic             dtlb_req_ready_o;
   logic [VPN_W-1:0] dtlb_req_vpn_i;

   logic             resp_valid_o;
   logic             resp_is_dtlb_o;
   logic [PPN_W-1:0] resp_ppn_o;
   logic [7:0]       resp_perm_o;
   logic [1:0]       resp_level_o;
   logic             resp_error_o;

   logic             ptw_req_valid_o;
   logic             ptw_req_ready_i;
   logic [VPN_W-1:0] ptw_req_vpn_o;
   logic             ptw_resp_valid_i;
   logic [PPN_W-1:0] ptw_resp_ppn_i;
   logic [7:0]       ptw_resp_perm_i;
   logic [1:0]       ptw_resp_level_i;
   logic             ptw_resp_error_i;

   modport slave (
      input  itlb_req_valid_i, itlb_req_vpn_i, dtlb_req_valid_i, dtlb_req_vpn_i,
      output itlb_req_ready_o, dtlb_req_ready_o,
      output resp_valid_o, resp_is_dtlb_o, resp_ppn_o, resp_perm_o, resp_level_o, resp_error_o,
      output ptw_req_valid_o, ptw_req_vpn_o,
      input  ptw_req_ready_i,
      input  ptw_resp_valid_i, ptw_resp_ppn_i, ptw_resp_perm_i, ptw_resp_level_i, ptw_resp_error_i
   );

   modport master (
      output itlb_req_valid_i, itlb_req_vpn_i, dtlb_req_valid_i, dtlb_req_vpn_i,
      input  itlb_req_ready_o, dtlb_req_ready_o,
      input  resp_valid_o, resp_is_dtlb_o, resp_ppn_o, resp_perm_o, resp_level_o, resp_error_o,
      input  ptw_req_valid_o, ptw_req_vpn_o,
      output ptw_req_ready_i,
      output ptw_resp_valid_i, ptw_resp_ppn_i, ptw_resp_perm_i, ptw_resp_level_i, ptw_resp_error_i
   );

endinterface

// File: rtl/cva6_stlb_rr_arb2.sv
// Two-way round-robin arbiter between the ITLB and DTLB miss requests.
// The pointer names the requester favoured on a tie; it resets to DTLB.
module cva6_stlb_rr_arb2
   import cva6_stlb_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic r_prio_dtlb;

   // grant the single requester, or the favoured one on a tie
   always_comb begin
      gnt_o = '0;
      if (en_i) begin
         if (req_i == 2'b11) begin
            gnt_o[REQ_DTLB] = r_prio_dtlb;
            gnt_o[REQ_ITLB] = ~r_prio_dtlb;
         end else begin
            gnt_o = req_i;
         end
      end
   end

   // after any grant, favour the other requester next time
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_prio_dtlb <= 1'b1;
      end else if (|gnt_o) begin
         r_prio_dtlb <= gnt_o[REQ_ITLB];
      end
   end

endmodule

// File: rtl/cva6_stlb_responder.sv
// Shared second-level Sv39 TLB: direct-mapped array answering L1 ITLB/DTLB
// misses, walking the page table through the PTW on a miss.
// Optional feature macro: CVA6_STLB_PERF_CNT_EN (hit/miss counters).
module cva6_stlb_responder
   import cva6_stlb_pkg::*;
#(
   parameter int unsigned DEPTH  = 64,
   parameter int unsigned VPN_W  = SV39_VPN_W,
   parameter int unsigned PPN_W  = SV39_PPN_W,
   parameter int unsigned ASID_W = SV39_ASID_W
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic [ASID_W-1:0] asid_i,
   cva6_stlb_responder_if.slave bus
`ifdef CVA6_STLB_PERF_CNT_EN
   ,
   output logic [31:0]       hit_cnt_o,
   output logic [31:0]       miss_cnt_o
`endif
);

   localparam int unsigned IDX_W = $clog2(DEPTH);

   stlb_state_t       r_state;
   logic [VPN_W-1:0]  r_vpn;
   logic              r_is_dtlb;
   logic [ASID_W-1:0] r_asid;
   logic              r_flushed;
   logic [PPN_W-1:0]  r_ppn;
   logic [7:0]        r_perm;
   logic [1:0]        r_level;
   logic              r_error;
   stlb_entry_t       r_tlb [DEPTH];

   logic [1:0]            w_gnt;
   logic [IDX_W-1:0]      w_idx;
   logic [SV39_VPN_W-1:0] w_tag;
   stlb_entry_t           w_entry;
   logic                  w_hit;
   logic                  w_miss;
   logic                  w_fill;

   cva6_stlb_rr_arb2 u_arb (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (r_state == ST_IDLE),
      .req_i ({bus.dtlb_req_valid_i, bus.itlb_req_valid_i}),
      .gnt_o (w_gnt)
   );

   assign w_idx   = r_vpn[IDX_W-1:0];
   assign w_tag   = SV39_VPN_W'(r_vpn >> IDX_W);
   assign w_entry = r_tlb[w_idx];
   // a flush in the lookup cycle forces a miss
   assign w_hit   = (r_state == ST_LOOKUP) && !flush_i && w_entry.valid && (w_entry.tag == w_tag) &&
                    (w_entry.perm[PERM_G] || (w_entry.asid == SV39_ASID_W'(r_asid)));
   assign w_miss  = (r_state == ST_LOOKUP) && !w_hit;
   // only clean 4KiB leaves with no flush since the grant are cached
   assign w_fill  = (r_state == ST_WALK_WAIT) && bus.ptw_resp_valid_i && !bus.ptw_resp_error_i &&
                    (bus.ptw_resp_level_i == LVL_4K) && !r_flushed;

   assign bus.itlb_req_ready_o = w_gnt[REQ_ITLB] && !rst_i;
   assign bus.dtlb_req_ready_o = w_gnt[REQ_DTLB] && !rst_i;
   assign bus.resp_valid_o     = (r_state == ST_RESP);
   assign bus.resp_is_dtlb_o   = (r_state == ST_RESP) ? r_is_dtlb : 1'b0;
   assign bus.resp_ppn_o       = (r_state == ST_RESP) ? r_ppn     : '0;
   assign bus.resp_perm_o      = (r_state == ST_RESP) ? r_perm    : '0;
   assign bus.resp_level_o     = (r_state == ST_RESP) ? r_level   : '0;
   assign bus.resp_error_o     = (r_state == ST_RESP) ? r_error   : 1'b0;
   assign bus.ptw_req_valid_o  = (r_state == ST_WALK_REQ);
   assign bus.ptw_req_vpn_o    = (r_state == ST_WALK_REQ) ? r_vpn : '0;

   // request/lookup/walk/response sequencing
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state   <= ST_IDLE;
         r_vpn     <= '0;
         r_is_dtlb <= 1'b0;
         r_asid    <= '0;
         r_flushed <= 1'b0;
         r_ppn     <= '0;
         r_perm    <= '0;
         r_level   <= '0;
         r_error   <= 1'b0;
      end else begin
         if (flush_i && (r_state != ST_IDLE)) begin
            r_flushed <= 1'b1;
         end
         case (r_state)
            ST_IDLE: begin
               if (|w_gnt) begin
                  r_vpn     <= w_gnt[REQ_DTLB] ? bus.dtlb_req_vpn_i : bus.itlb_req_vpn_i;
                  r_is_dtlb <= w_gnt[REQ_DTLB];
                  r_asid    <= asid_i;
                  r_flushed <= 1'b0;
                  r_state   <= ST_LOOKUP;
               end
            end
            ST_LOOKUP: begin
               if (w_hit) begin
                  r_ppn   <= PPN_W'(w_entry.ppn);
                  r_perm  <= w_entry.perm;
                  r_level <= LVL_4K;
                  r_error <= 1'b0;
                  r_state <= ST_RESP;
               end else begin
                  r_state <= ST_WALK_REQ;
               end
            end
            ST_WALK_REQ: begin
               if (bus.ptw_req_ready_i) begin
                  r_state <= ST_WALK_WAIT;
               end
            end
            ST_WALK_WAIT: begin
               if (bus.ptw_resp_valid_i) begin
                  r_ppn   <= bus.ptw_resp_ppn_i;
                  r_perm  <= bus.ptw_resp_perm_i;
                  r_level <= bus.ptw_resp_level_i;
                  r_error <= bus.ptw_resp_error_i;
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // entry array: flush clears all valid bits and wins over a same-cycle fill
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_tlb[i] <= '0;
         end
      end else if (flush_i) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            r_tlb[i].valid <= 1'b0;
         end
      end else if (w_fill) begin
         r_tlb[w_idx] <= '{valid: 1'b1,
                           tag:   w_tag,
                           asid:  SV39_ASID_W'(r_asid),
                           ppn:   SV39_PPN_W'(bus.ptw_resp_ppn_i),
                           perm:  bus.ptw_resp_perm_i};
      end
   end

`ifdef CVA6_STLB_PERF_CNT_EN
   logic [31:0] r_hit_cnt;
   logic [31:0] r_miss_cnt;

   // saturating lookup-outcome counters, untouched by flush
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_hit_cnt  <= '0;
         r_miss_cnt <= '0;
      end else begin
         if (w_hit && (r_hit_cnt != '1)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
         end
         if (w_miss && (r_miss_cnt != '1)) begin
            r_miss_cnt <= r_miss_cnt + 32'd1;
         end
      end
   end

   assign hit_cnt_o  = r_hit_cnt;
   assign miss_cnt_o = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cva6_stlb_responder.sv
// Directed self-checking bench for the shared-TLB responder.
module tb_cva6_stlb_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [15:0] asid;
   int          n_cmp = 0;
   int          n_fail = 0;
   int          n_both_ready = 0;

   always #5 clk = ~clk;

   cva6_stlb_responder_if #(.VPN_W(27), .PPN_W(44)) bus ();

`ifdef CVA6_STLB_PERF_CNT_EN
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;
`endif

   cva6_stlb_responder #(.DEPTH(64), .VPN_W(27), .PPN_W(44), .ASID_W(16)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .flush_i (flush),
      .asid_i  (asid),
      .bus     (bus)
`ifdef CVA6_STLB_PERF_CNT_EN
      ,
      .hit_cnt_o  (hit_cnt),
      .miss_cnt_o (miss_cnt)
`endif
   );

   always @(negedge clk) begin
      if (bus.itlb_req_ready_o && bus.dtlb_req_ready_o) n_both_ready++;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   function automatic logic [56:0] resp_word();
      return {bus.resp_valid_o, bus.resp_is_dtlb_o, bus.resp_ppn_o, bus.resp_perm_o,
              bus.resp_level_o, bus.resp_error_o};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      flush = 1'b0;
      bus.itlb_req_valid_i = 1'b0;
      bus.dtlb_req_valid_i = 1'b0;
      bus.ptw_req_ready_i = 1'b0;
      bus.ptw_resp_valid_i = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // returns in the cycle after the grant (the lookup cycle)
   task automatic grant(input logic d, input logic [26:0] vpn, input logic [15:0] a, output logic ok);
      ok = 1'b0;
      asid = a;
      if (d) begin
         bus.dtlb_req_valid_i = 1'b1;
         bus.dtlb_req_vpn_i = vpn;
      end else begin
         bus.itlb_req_valid_i = 1'b1;
         bus.itlb_req_vpn_i = vpn;
      end
      for (int i = 0; i < 10 && !ok; i++) begin
         #1;
         ok = d ? bus.dtlb_req_ready_o : bus.itlb_req_ready_o;
         @(posedge clk);
         #1;
      end
      if (d) bus.dtlb_req_valid_i = 1'b0;
      else bus.itlb_req_valid_i = 1'b0;
   endtask

   // handshakes the walk request and answers it; returns in the response cycle
   task automatic serve_walk(input logic [43:0] ppn, input logic [7:0] perm, input logic [1:0] lvl,
                             input logic err, output logic ok, output logic [26:0] vpn_seen);
      ok = 1'b0;
      vpn_seen = '0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (bus.ptw_req_valid_o) begin
            ok = 1'b1;
            vpn_seen = bus.ptw_req_vpn_o;
            bus.ptw_req_ready_i = 1'b1;
         end
         tick();
      end
      bus.ptw_req_ready_i = 1'b0;
      if (ok) begin
         bus.ptw_resp_valid_i = 1'b1;
         bus.ptw_resp_ppn_i = ppn;
         bus.ptw_resp_perm_i = perm;
         bus.ptw_resp_level_i = lvl;
         bus.ptw_resp_error_i = err;
         tick();
         bus.ptw_resp_valid_i = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      flush = 1'b0;
      asid = '0;
      bus.itlb_req_valid_i = 1'b0;
      bus.dtlb_req_valid_i = 1'b0;
      bus.itlb_req_vpn_i = '0;
      bus.dtlb_req_vpn_i = '0;
      bus.ptw_req_ready_i = 1'b0;
      bus.ptw_resp_valid_i = 1'b0;
      bus.ptw_resp_ppn_i = '0;
      bus.ptw_resp_perm_i = '0;
      bus.ptw_resp_level_i = '0;
      bus.ptw_resp_error_i = 1'b0;
      tick();
      n_cmp++;
      if ({resp_word(), bus.ptw_req_valid_o, bus.ptw_req_vpn_o, bus.itlb_req_ready_o, bus.dtlb_req_ready_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got resp=%h ptw=%b/%h rdy=%b%b expected all 0", resp_word(),
                  bus.ptw_req_valid_o, bus.ptw_req_vpn_o, bus.itlb_req_ready_o, bus.dtlb_req_ready_o);
      end
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({bus.resp_valid_o, bus.ptw_req_valid_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL idle_outputs: got resp_valid=%b ptw_valid=%b expected 0 0", bus.resp_valid_o, bus.ptw_req_valid_o);
      end
   endtask

   task automatic test_cold_miss();
      logic ok;
      logic [26:0] v;
      apply_reset();
      grant(1'b1, 27'h0001234, 16'd5, ok);
      n_cmp++;
      if (ok !== 1'b1) begin n_fail++; $display("FAIL cold_grant: got %b expected 1", ok); end
      tick();
      n_cmp++;
      if ({bus.ptw_req_valid_o, bus.ptw_req_vpn_o} !== {1'b1, 27'h0001234}) begin
         n_fail++;
         $display("FAIL cold_ptw_req: got %b/%h expected 1/0001234", bus.ptw_req_valid_o, bus.ptw_req_vpn_o);
      end
      tick();
      n_cmp++;
      if ({bus.ptw_req_valid_o, bus.ptw_req_vpn_o} !== {1'b1, 27'h0001234}) begin
         n_fail++;
         $display("FAIL cold_ptw_hold: got %b/%h expected 1/0001234", bus.ptw_req_valid_o, bus.ptw_req_vpn_o);
      end
      serve_walk(44'h80123, 8'hCF, 2'd0, 1'b0, ok, v);
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b1, 44'h80123, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL cold_resp: got %h expected %h", resp_word(), {1'b1, 1'b1, 44'h80123, 8'hCF, 2'd0, 1'b0});
      end
      tick();
      n_cmp++;
      if (resp_word() !== '0) begin
         n_fail++;
         $display("FAIL cold_resp_pulse: got %h expected 0", resp_word());
      end
      grant(1'b1, 27'h0001234, 16'd5, ok);
      n_cmp++;
      if ({ok, bus.resp_valid_o, bus.ptw_req_valid_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL hit_n1: got ok/resp/ptw=%b%b%b expected 100", ok, bus.resp_valid_o, bus.ptw_req_valid_o);
      end
      tick();
      n_cmp++;
      if ({resp_word(), bus.ptw_req_valid_o} !== {1'b1, 1'b1, 44'h80123, 8'hCF, 2'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL hit_n2: got %h ptw=%b expected %h ptw=0", resp_word(), bus.ptw_req_valid_o,
                  {1'b1, 1'b1, 44'h80123, 8'hCF, 2'd0, 1'b0});
      end
      tick();
   endtask

   task automatic test_asid_global();
      logic ok;
      logic [26:0] v;
      apply_reset();
      grant(1'b1, 27'h40, 16'd3, ok);
      serve_walk(44'h333, 8'hCF, 2'd0, 1'b0, ok, v);
      tick();
      grant(1'b1, 27'h40, 16'd4, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL asid_mismatch_walk: got ptw_valid=%b expected 1", bus.ptw_req_valid_o);
      end
      serve_walk(44'h444, 8'hEF, 2'd0, 1'b0, ok, v);
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b1, 44'h444, 8'hEF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL asid_refill_resp: got %h expected %h", resp_word(), {1'b1, 1'b1, 44'h444, 8'hEF, 2'd0, 1'b0});
      end
      tick();
      grant(1'b1, 27'h40, 16'd7, ok);
      tick();
      n_cmp++;
      if ({resp_word(), bus.ptw_req_valid_o} !== {1'b1, 1'b1, 44'h444, 8'hEF, 2'd0, 1'b0, 1'b0}) begin
         n_fail++;
         $display("FAIL global_hit: got %h ptw=%b expected %h ptw=0", resp_word(), bus.ptw_req_valid_o,
                  {1'b1, 1'b1, 44'h444, 8'hEF, 2'd0, 1'b0});
      end
      tick();
   endtask

   task automatic test_simultaneous();
      logic ok;
      logic [26:0] v;
      apply_reset();
      asid = 16'd1;
      bus.itlb_req_vpn_i = 27'h11;
      bus.dtlb_req_vpn_i = 27'h22;
      bus.itlb_req_valid_i = 1'b1;
      bus.dtlb_req_valid_i = 1'b1;
      #1;
      n_cmp++;
      if ({bus.itlb_req_ready_o, bus.dtlb_req_ready_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL rr_first: got itlb/dtlb ready=%b%b expected 01", bus.itlb_req_ready_o, bus.dtlb_req_ready_o);
      end
      @(posedge clk);
      #1;
      bus.dtlb_req_valid_i = 1'b0;
      n_cmp++;
      if ({bus.itlb_req_ready_o, bus.dtlb_req_ready_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL rr_busy_ready: got %b%b expected 00", bus.itlb_req_ready_o, bus.dtlb_req_ready_o);
      end
      serve_walk(44'h22A, 8'hCF, 2'd0, 1'b0, ok, v);
      n_cmp++;
      if ({v, resp_word()} !== {27'h22, 1'b1, 1'b1, 44'h22A, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL rr_dtlb_walk: got vpn=%h resp=%h expected vpn=22 resp=%h", v, resp_word(),
                  {1'b1, 1'b1, 44'h22A, 8'hCF, 2'd0, 1'b0});
      end
      tick();
      bus.dtlb_req_valid_i = 1'b1;
      #1;
      n_cmp++;
      if ({bus.itlb_req_ready_o, bus.dtlb_req_ready_o} !== 2'b10) begin
         n_fail++;
         $display("FAIL rr_second: got itlb/dtlb ready=%b%b expected 10", bus.itlb_req_ready_o, bus.dtlb_req_ready_o);
      end
      @(posedge clk);
      #1;
      bus.itlb_req_valid_i = 1'b0;
      bus.dtlb_req_valid_i = 1'b0;
      serve_walk(44'h11A, 8'hCF, 2'd0, 1'b0, ok, v);
      n_cmp++;
      if ({v, resp_word()} !== {27'h11, 1'b1, 1'b0, 44'h11A, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL rr_itlb_walk: got vpn=%h resp=%h expected vpn=11 resp=%h", v, resp_word(),
                  {1'b1, 1'b0, 44'h11A, 8'hCF, 2'd0, 1'b0});
      end
      tick();
      n_cmp++;
      if (n_both_ready !== 0) begin
         n_fail++;
         $display("FAIL rr_exclusive: got %0d cycles with both readies expected 0", n_both_ready);
      end
   endtask

   task automatic test_flush_walk();
      logic ok;
      logic [26:0] v;
      apply_reset();
      grant(1'b0, 27'h300, 16'd1, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_walk_req: got %b expected 1", bus.ptw_req_valid_o);
      end
      bus.ptw_req_ready_i = 1'b1;
      tick();
      bus.ptw_req_ready_i = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      bus.ptw_resp_valid_i = 1'b1;
      bus.ptw_resp_ppn_i = 44'h999;
      bus.ptw_resp_perm_i = 8'hCF;
      bus.ptw_resp_level_i = 2'd0;
      bus.ptw_resp_error_i = 1'b0;
      tick();
      bus.ptw_resp_valid_i = 1'b0;
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b0, 44'h999, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_walk_resp: got %h expected %h", resp_word(), {1'b1, 1'b0, 44'h999, 8'hCF, 2'd0, 1'b0});
      end
      tick();
      grant(1'b0, 27'h300, 16'd1, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_not_cached: got ptw_valid=%b expected 1", bus.ptw_req_valid_o);
      end
      serve_walk(44'h9A9, 8'hCF, 2'd0, 1'b0, ok, v);
      tick();
      grant(1'b0, 27'h300, 16'd1, ok);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_cmp++;
      if ({bus.resp_valid_o, bus.ptw_req_valid_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL flush_lookup_miss: got resp/ptw=%b%b expected 01", bus.resp_valid_o, bus.ptw_req_valid_o);
      end
      serve_walk(44'h9B9, 8'hCF, 2'd0, 1'b0, ok, v);
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b0, 44'h9B9, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL flush_lookup_resp: got %h expected %h", resp_word(), {1'b1, 1'b0, 44'h9B9, 8'hCF, 2'd0, 1'b0});
      end
      tick();
   endtask

   task automatic test_superpage_error();
      logic ok;
      logic [26:0] v;
      apply_reset();
      grant(1'b1, 27'h500, 16'd2, ok);
      serve_walk(44'h40000, 8'hCF, 2'd1, 1'b0, ok, v);
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b1, 44'h40000, 8'hCF, 2'd1, 1'b0}) begin
         n_fail++;
         $display("FAIL superpage_resp: got %h expected %h", resp_word(), {1'b1, 1'b1, 44'h40000, 8'hCF, 2'd1, 1'b0});
      end
      tick();
      grant(1'b1, 27'h500, 16'd2, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL superpage_not_cached: got ptw_valid=%b expected 1", bus.ptw_req_valid_o);
      end
      serve_walk(44'h0, 8'h00, 2'd0, 1'b1, ok, v);
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b1, 44'h0, 8'h00, 2'd0, 1'b1}) begin
         n_fail++;
         $display("FAIL error_resp: got %h expected %h", resp_word(), {1'b1, 1'b1, 44'h0, 8'h00, 2'd0, 1'b1});
      end
      tick();
      grant(1'b1, 27'h500, 16'd2, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL error_not_cached: got ptw_valid=%b expected 1", bus.ptw_req_valid_o);
      end
      serve_walk(44'h5555, 8'hCF, 2'd0, 1'b0, ok, v);
      tick();
      grant(1'b1, 27'h500, 16'd2, ok);
      tick();
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b1, 44'h5555, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL leaf_after_error_hit: got %h expected %h", resp_word(), {1'b1, 1'b1, 44'h5555, 8'hCF, 2'd0, 1'b0});
      end
      tick();
   endtask

   task automatic test_alias_reset();
      logic ok;
      logic [26:0] v;
      apply_reset();
      grant(1'b1, 27'h40, 16'd2, ok);
      serve_walk(44'h111, 8'hCF, 2'd0, 1'b0, ok, v);
      tick();
      grant(1'b1, 27'h80, 16'd2, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL alias_tag_miss: got ptw_valid=%b expected 1", bus.ptw_req_valid_o);
      end
      serve_walk(44'h222, 8'hCF, 2'd0, 1'b0, ok, v);
      tick();
      grant(1'b1, 27'h80, 16'd2, ok);
      tick();
      n_cmp++;
      if (resp_word() !== {1'b1, 1'b1, 44'h222, 8'hCF, 2'd0, 1'b0}) begin
         n_fail++;
         $display("FAIL alias_new_hit: got %h expected %h", resp_word(), {1'b1, 1'b1, 44'h222, 8'hCF, 2'd0, 1'b0});
      end
      tick();
      grant(1'b1, 27'h40, 16'd2, ok);
      tick();
      n_cmp++;
      if (bus.ptw_req_valid_o !== 1'b1) begin
         n_fail++;
         $display("FAIL alias_evicted: got ptw_valid=%b expected 1", bus.ptw_req_valid_o);
      end
      rst = 1'b1;
      #1;
      n_cmp++;
      if ({resp_word(), bus.ptw_req_valid_o, bus.ptw_req_vpn_o, bus.itlb_req_ready_o, bus.dtlb_req_ready_o} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_walk: got resp=%h ptw=%b/%h expected all 0", resp_word(), bus.ptw_req_valid_o, bus.ptw_req_vpn_o);
      end
      tick();
      rst = 1'b0;
      tick();
      n_cmp++;
      if ({bus.resp_valid_o, bus.ptw_req_valid_o} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_no_resp: got resp/ptw=%b%b expected 00", bus.resp_valid_o, bus.ptw_req_valid_o);
      end
      grant(1'b1, 27'h80, 16'd2, ok);
      tick();
      n_cmp++;
      if ({bus.resp_valid_o, bus.ptw_req_valid_o} !== 2'b01) begin
         n_fail++;
         $display("FAIL reset_invalidates: got resp/ptw=%b%b expected 01", bus.resp_valid_o, bus.ptw_req_valid_o);
      end
      serve_walk(44'h333, 8'hCF, 2'd0, 1'b0, ok, v);
      tick();
   endtask

   initial begin
      test_reset();
      test_cold_miss();
      test_asid_global();
      test_simultaneous();
      test_flush_walk();
      test_superpage_error();
      test_alias_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
